imem_loader: RTL
================

# imem_loader

Test-harness controller that sequences a ToastCore run. It holds the core in reset while a program image streams in over a valid/ready interface and is written word-by-word into instruction memory. It then releases the core and watches the fetched instruction for the end-of-test `unimp` encoding or a cycle-budget timeout. It sits between the bench/host program source and the core's IMEM write port and `Reset_n` input.

## Interface
- `ADDR_WIDTH`, 11: IMEM word-address width; depth = 2^ADDR_WIDTH words.
- `RST_HOLD`, 4: cycles core stays in reset after the last IMEM write; legal range 1..255.
- `MAX_CYCLES`, 100000: run-cycle budget before timeout; must be ≥1.
- `END_MARKER`, 32'hC0001073: instruction word that signals end of test.

Ports:
- `Clk` in 1: sole clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or TIMEOUT.
- `ld_valid` in 1: load word valid.
- `ld_ready` out 1: loader accepts a word.
- `ld_data` in 32: program word.
- `ld_last` in 1: marks the final word of the image.
- `imem_wr_en` out 1: IMEM write strobe.
- `imem_wr_addr` out ADDR_WIDTH: IMEM word address.
- `imem_wr_data` out 32: IMEM write data.
- `core_reset_n` out 1: drives the core's `Reset_n`.
- `if_instruction` in 32: instruction currently in the core's IF stage.
- `busy` out 1: high in LOAD, HOLD and RUN.
- `done` out 1: END_MARKER seen.
- `timeout` out 1: budget exhausted.
- `overflow` out 1: image exceeded IMEM depth.
- `word_count` out ADDR_WIDTH+1: words accepted in the current load.
- `run_cycles` out 32: cycles spent in RUN.

## Operation
- States: IDLE, LOAD, HOLD, RUN, DONE, TIMEOUT.
- IDLE → LOAD on `start`.
  - Entering LOAD clears `word_count`, `run_cycles`, `done`, `timeout` and `overflow`.
- LOAD:
  - `ld_ready` = 1.
  - Each handshake (`ld_valid` && `ld_ready`) writes `ld_data` at address `word_count[ADDR_WIDTH-1:0]` and increments `word_count`.
  - A handshake with `ld_last` → HOLD.
  - A handshake at address 2^ADDR_WIDTH-1 without `ld_last` sets `overflow` and → HOLD; the stream is no longer accepted.
- HOLD: counts RST_HOLD cycles, then → RUN.
- RUN:
  - `core_reset_n` = 1; `run_cycles` increments every cycle.
  - `if_instruction` == END_MARKER → DONE.
  - Otherwise, `run_cycles` reaching MAX_CYCLES-1 → TIMEOUT.
  - If both hold in the same cycle, DONE wins.
- DONE and TIMEOUT:
  - `core_reset_n` = 0; sticky flags stay high.
  - `start` → LOAD, a full restart.
- `core_reset_n` = 0 in every state except RUN.
- `start` outside IDLE/DONE/TIMEOUT is ignored.

## Timing
- On `Reset_n` low:
  - state = IDLE.
  - All outputs 0: `core_reset_n` = 0, `ld_ready` = 0, `imem_wr_en` = 0, `imem_wr_addr` = 0, `imem_wr_data` = 0, all flags and counters 0.
- IMEM write outputs are registered: a handshake in cycle N gives `imem_wr_en` = 1 with the matching addr/data in cycle N+1, for exactly one cycle per word.
- `ld_ready` is combinational from state (LOAD only), so back-to-back words sustain 1 word/cycle.
  - `ld_ready` drops in the cycle after the last/overflow handshake.
- `core_reset_n` rises RST_HOLD+1 cycles after the final `imem_wr_en` cycle. This spacing is exact, so the last write lands before the core's first fetch.
- `done`/`timeout` assert, and `core_reset_n` falls, one cycle after the deciding RUN cycle. `run_cycles` freezes at that point.
- `Reset_n` assertion mid-load or mid-run aborts immediately, with no partial cleanup. IMEM contents already written are left as is.

## Structure
- Shared package `testbench_pkg`:
  - State enum `loader_state_t`.
  - Constant `RV_UNIMP = 32'hC0001073`, which is the END_MARKER default.
- One optional sub-module, `cycle_counter`: a 32-bit enable/clear counter reused for the HOLD and RUN counts.
- All else is a single FSM in `imem_loader`.

## Test plan
- Load 4 words (0x00000013 ×3, then 0xC0001073 with `ld_last`) back-to-back → writes at addr 0..3, `word_count` = 4.
  - `core_reset_n` high RST_HOLD+1 cycles after the last write.
  - Drive `if_instruction` = 0xC0001073 → `done` = 1, `core_reset_n` = 0.
- Same image with `ld_valid` toggling every other cycle → identical writes; `imem_wr_en` pulses only on handshakes.
- MAX_CYCLES = 100, END_MARKER never presented → `timeout` = 1 with `run_cycles` = 100, `done` = 0.
- ADDR_WIDTH = 2, stream 6 words without `ld_last` → 4 writes at addr 0..3.
  - `overflow` = 1, `ld_ready` low after the 4th handshake, run proceeds.
- `Reset_n` pulsed low after 2 of 4 words → all outputs 0 at once, state IDLE.
  - A subsequent `start` reloads from addr 0.
- After `done`, a second `start` → flags cleared, new load begins at addr 0; `start` pulsed during RUN is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and constants for the ToastCore program loader.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package testbench_pkg;

  // Sequencer phases. Each image load moves through these in order.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } loader_state_t;

  // RISC-V 'unimp' (csrrw x0, cycle, x0). Programs end with it to stop the run.
  localparam logic [31:0] RV_UNIMP = 32'hC0001073;

  // A new load may only begin from rest, never while a run is in flight.
  function automatic logic start_allowed(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/imem_loader_cycle_counter.sv
// 32-bit cycle counter with synchronous clear (priority) and count enable.
// Latency: count reflects clr/en one cycle after they are sampled.
// Backpressure: none; counts every enabled cycle and wraps at 2^32.
module cycle_counter (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);

  // Clear wins over enable so a phase can restart the count on its first cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= 32'd0;
    end else if (clr) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image into IMEM with the core held in reset, then runs it until unimp or budget.
// Latency: IMEM write one cycle after handshake; core_reset_n rises RST_HOLD+1 cycles after last write.
// Backpressure: ld_ready high only in LOAD (1 word/cycle); drops the cycle after last/overflow handshake.
module imem_loader
  import testbench_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter int          RST_HOLD   = 4,
  parameter int          MAX_CYCLES = 100000,
  parameter logic [31:0] END_MARKER = RV_UNIMP
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [31:0]           imem_wr_data,
  output logic                  core_reset_n,
  input  logic [31:0]           if_instruction,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           run_cycles
);

  // HOLD spans the final write cycle plus RST_HOLD more, so it ends when the
  // counter (zero on HOLD entry) reaches RST_HOLD.
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD);
  // run_cycles equals the number of RUN cycles already completed; the cycle
  // that sees MAX_CYCLES-1 is the last one the budget allows.
  localparam logic [31:0] RUN_LAST  = 32'(MAX_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] WC_ONE = (ADDR_WIDTH+1)'(1);

  loader_state_t state;
  loader_state_t state_nxt;

  logic        hs;
  logic        load_enter;
  logic        ovf_set;
  logic        done_set;
  logic        timeout_set;
  logic        addr_at_top;
  logic        hold_done;
  logic        end_seen;
  logic        budget_hit;
  logic        hold_clr;
  logic        hold_en;
  logic        run_en;
  logic [31:0] hold_cnt;

  assign addr_at_top = (word_count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
  assign hold_done   = (hold_cnt == HOLD_LAST);
  assign end_seen    = (if_instruction == END_MARKER);
  assign budget_hit  = (run_cycles == RUN_LAST);

  // The hold counter idles at zero outside HOLD so it starts fresh each time.
  assign hold_clr = (state != ST_HOLD);
  assign hold_en  = (state == ST_HOLD);
  // run_cycles freezes as soon as RUN is left and is only cleared by a new load.
  assign run_en   = (state == ST_RUN);

  cycle_counter u_hold_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (hold_clr),
    .en      (hold_en),
    .count   (hold_cnt)
  );

  cycle_counter u_run_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (load_enter),
    .en      (run_en),
    .count   (run_cycles)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the state-derived outputs and per-cycle events.
  always_comb begin
    state_nxt    = state;
    ld_ready     = 1'b0;
    core_reset_n = 1'b0;
    busy         = 1'b0;
    hs           = 1'b0;
    load_enter   = 1'b0;
    ovf_set      = 1'b0;
    done_set     = 1'b0;
    timeout_set  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start && start_allowed(state)) begin
          load_enter = 1'b1;
          state_nxt  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        hs       = ld_valid;
        if (hs) begin
          if (ld_last) begin
            state_nxt = ST_HOLD;
          end else if (addr_at_top) begin
            // Image is larger than IMEM: keep what fits and refuse the rest.
            ovf_set   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        busy = 1'b1;
        if (hold_done) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        busy         = 1'b1;
        core_reset_n = 1'b1;
        // A marker fetched on the budget's last cycle still counts as a pass.
        if (end_seen) begin
          done_set  = 1'b1;
          state_nxt = ST_DONE;
        end else if (budget_hit) begin
          timeout_set = 1'b1;
          state_nxt   = ST_TIMEOUT;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered IMEM write port: one strobe per accepted word.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= 32'd0;
    end else begin
      imem_wr_en <= hs;
      if (hs) begin
        imem_wr_addr <= word_count[ADDR_WIDTH-1:0];
        imem_wr_data <= ld_data;
      end
    end
  end

  // Word counter doubles as the next write address; a new load restarts it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      word_count <= '0;
    end else if (load_enter) begin
      word_count <= '0;
    end else if (hs) begin
      word_count <= word_count + WC_ONE;
    end
  end

  // Sticky result flags, held until the next load starts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else if (load_enter) begin
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (done_set) begin
        done <= 1'b1;
      end
      if (timeout_set) begin
        timeout <= 1'b1;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
